// File: rtl/calc_controller.sv
// Keypad-to-stack controller for the RPN calculator.
// Turns numpad press events into one-cycle push/pop/write strobes for the operand
// stack, runs a restoring divider for divide/modulo, and keeps a sticky error flag.
module calc_controller #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int COUNT_W = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [4:0]         i_key,
    input  logic               i_alt,
    input  logic [WIDTH-1:0]   i_top,
    input  logic [WIDTH-1:0]   i_next,
    input  logic [COUNT_W-1:0] i_count,
    output logic               o_stack_push,
    output logic               o_stack_pop,
    output logic               o_stack_write,
    output logic [WIDTH-1:0]   o_stack_value,
    output logic               o_busy,
    output logic               o_error
);

    localparam int ITER_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Key ids of the function column
    localparam logic [3:0] KEY_A = 4'hC;
    localparam logic [3:0] KEY_B = 4'hD;
    localparam logic [3:0] KEY_C = 4'hE;
    localparam logic [3:0] KEY_D = 4'hF;

    localparam logic [WIDTH+3:0] DIGIT_MUL = (WIDTH+4)'(10);

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StDone
    } state_t;

    state_t              r_state;
    logic                r_key_held;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_quo;
    logic [WIDTH-1:0]    r_div;
    logic [ITER_W-1:0]   r_iter;
    logic                r_is_mod;

    logic                w_press;
    logic                w_is_digit;
    logic [3:0]          w_digit;
    logic                w_empty;
    logic                w_full;
    logic                w_underflow;
    logic [WIDTH+3:0]    w_top_ext;
    logic [WIDTH+3:0]    w_digit_res;
    logic [WIDTH:0]      w_sum;
    logic [2*WIDTH-1:0]  w_prod;
    logic [WIDTH-1:0]    w_arith_res;
    logic                w_arith_err;
    logic [WIDTH:0]      w_shift;
    logic [WIDTH:0]      w_sub;
    logic                w_ge;

    assign w_press     = i_key[4] & ~r_key_held;
    assign w_empty     = (i_count == '0);
    assign w_full      = (i_count == COUNT_W'(DEPTH));
    assign w_underflow = (i_count < COUNT_W'(2));

    // An empty stack behaves as if top were zero for digit entry
    assign w_top_ext   = w_empty ? '0 : {4'b0000, i_top};
    assign w_digit_res = w_top_ext * DIGIT_MUL + {{WIDTH{1'b0}}, w_digit};

    assign w_sum  = {1'b0, i_next} + {1'b0, i_top};
    assign w_prod = {{WIDTH{1'b0}}, i_next} * {{WIDTH{1'b0}}, i_top};

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_sub   = w_shift - {1'b0, r_div};
    assign w_ge    = (w_shift >= {1'b0, r_div});

    // Numpad id to digit value
    always_comb begin
        w_is_digit = 1'b1;
        w_digit    = 4'd0;
        case (i_key[3:0])
            4'h0:    w_digit = 4'd1;
            4'h1:    w_digit = 4'd4;
            4'h2:    w_digit = 4'd7;
            4'h3:    w_digit = 4'd0;
            4'h4:    w_digit = 4'd2;
            4'h5:    w_digit = 4'd5;
            4'h6:    w_digit = 4'd8;
            4'h8:    w_digit = 4'd3;
            4'h9:    w_digit = 4'd6;
            4'hA:    w_digit = 4'd9;
            default: w_is_digit = 1'b0;
        endcase
    end

    // Result and range check of the non-alternate binary operators
    always_comb begin
        w_arith_res = '0;
        w_arith_err = 1'b0;
        case (i_key[3:0])
            KEY_B: begin
                w_arith_res = w_sum[WIDTH-1:0];
                w_arith_err = w_sum[WIDTH];
            end
            KEY_C: begin
                w_arith_res = i_next - i_top;
                w_arith_err = (i_next < i_top);
            end
            KEY_D: begin
                w_arith_res = w_prod[WIDTH-1:0];
                w_arith_err = |w_prod[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    // Control FSM, divider datapath and registered command outputs
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_key_held    <= 1'b0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_div         <= '0;
            r_iter        <= '0;
            r_is_mod      <= 1'b0;
            o_stack_push  <= 1'b0;
            o_stack_pop   <= 1'b0;
            o_stack_write <= 1'b0;
            o_stack_value <= '0;
            o_busy        <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            r_key_held    <= i_key[4];
            o_stack_push  <= 1'b0;
            o_stack_pop   <= 1'b0;
            o_stack_write <= 1'b0;
            o_stack_value <= '0;
            case (r_state)
                StIdle: begin
                    if (w_press) begin
                        if (o_error) begin
                            // Only alt+D (clear) gets through while the error is set
                            if (i_alt && i_key[3:0] == KEY_D) begin
                                o_error <= 1'b0;
                            end
                        end else if (w_is_digit) begin
                            if (|w_digit_res[WIDTH+3:WIDTH]) begin
                                o_error <= 1'b1;
                            end else begin
                                o_stack_push  <= w_empty;
                                o_stack_write <= ~w_empty;
                                o_stack_value <= w_digit_res[WIDTH-1:0];
                            end
                        end else begin
                            case (i_key[3:0])
                                KEY_A: begin
                                    if (w_full) begin
                                        o_error <= 1'b1;
                                    end else begin
                                        o_stack_push <= 1'b1;
                                    end
                                end
                                KEY_B, KEY_C, KEY_D: begin
                                    if (i_alt && i_key[3:0] == KEY_D) begin
                                        // Clear with no error pending: nothing to do
                                    end else if (w_underflow) begin
                                        o_error <= 1'b1;
                                    end else if (i_alt) begin
                                        if (i_top == '0) begin
                                            o_error <= 1'b1;
                                        end else begin
                                            r_state  <= StDiv;
                                            o_busy   <= 1'b1;
                                            r_quo    <= i_next;
                                            r_rem    <= '0;
                                            r_div    <= i_top;
                                            r_iter   <= '0;
                                            r_is_mod <= (i_key[3:0] == KEY_C);
                                        end
                                    end else if (w_arith_err) begin
                                        o_error <= 1'b1;
                                    end else begin
                                        o_stack_pop   <= 1'b1;
                                        o_stack_write <= 1'b1;
                                        o_stack_value <= w_arith_res;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                StDiv: begin
                    r_rem  <= w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_quo  <= {r_quo[WIDTH-2:0], w_ge};
                    r_iter <= r_iter + ITER_W'(1);
                    if (r_iter == ITER_W'(WIDTH - 1)) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    o_stack_pop   <= 1'b1;
                    o_stack_write <= 1'b1;
                    o_stack_value <= r_is_mod ? r_rem : r_quo;
                    o_busy        <= 1'b0;
                    r_state       <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller: directed scenarios plus randomized
// key/operand stimulus checked against an arithmetic reference model.
module tb_calc_controller;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 16;
    localparam int COUNT_W = 6;

    logic               i_clock = 1'b0;
    logic               i_reset;
    logic [4:0]         i_key;
    logic               i_alt;
    logic [WIDTH-1:0]   i_top;
    logic [WIDTH-1:0]   i_next;
    logic [COUNT_W-1:0] i_count;
    logic               o_stack_push;
    logic               o_stack_pop;
    logic               o_stack_write;
    logic [WIDTH-1:0]   o_stack_value;
    logic               o_busy;
    logic               o_error;

    int n_checks = 0;
    int n_pass   = 0;
    logic m_err  = 1'b0;

    typedef struct packed {
        logic        push;
        logic        pop;
        logic        wr;
        logic [31:0] val;
        logic        err;
        logic        div;
    } exp_t;

    calc_controller #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .COUNT_W(COUNT_W)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_key        (i_key),
        .i_alt        (i_alt),
        .i_top        (i_top),
        .i_next       (i_next),
        .i_count      (i_count),
        .o_stack_push (o_stack_push),
        .o_stack_pop  (o_stack_pop),
        .o_stack_write(o_stack_write),
        .o_stack_value(o_stack_value),
        .o_busy       (o_busy),
        .o_error      (o_error)
    );

    always #5 i_clock = ~i_clock;

    task automatic cycle();
        @(posedge i_clock);
        #1;
    endtask

    function automatic int digit_of(input logic [3:0] id);
        case (id)
            4'h0: return 1;
            4'h1: return 4;
            4'h2: return 7;
            4'h3: return 0;
            4'h4: return 2;
            4'h5: return 5;
            4'h6: return 8;
            4'h8: return 3;
            4'h9: return 6;
            4'hA: return 9;
            default: return -1;
        endcase
    endfunction

    // Calculator behaviour for one key press, in plain 64-bit arithmetic
    function automatic exp_t model(input logic [3:0] id, input logic a, input logic [31:0] top,
                                   input logic [31:0] nxt, input int cnt, input logic err);
        exp_t e;
        longint unsigned t, n, r;
        int d;
        e = '0;
        e.err = err;
        t = longint'(top);
        n = longint'(nxt);
        if (err) begin
            if (a && id == 4'hF) e.err = 1'b0;
            return e;
        end
        d = digit_of(id);
        if (d >= 0) begin
            if (cnt == 0) t = 0;
            r = t * 10 + longint'(d);
            if (r > 64'hFFFF_FFFF) e.err = 1'b1;
            else begin
                e.push = (cnt == 0);
                e.wr   = (cnt != 0);
                e.val  = r[31:0];
            end
        end else if (id == 4'hC) begin
            if (cnt == DEPTH) e.err = 1'b1;
            else e.push = 1'b1;
        end else if (id == 4'hF && a) begin
            // clear with no error: nothing
        end else if (id == 4'hD || id == 4'hE || id == 4'hF) begin
            if (cnt < 2) e.err = 1'b1;
            else if (a) begin
                if (t == 0) e.err = 1'b1;
                else begin
                    e.div = 1'b1;
                    r = (id == 4'hD) ? n / t : n % t;
                    e.val = r[31:0];
                end
            end else begin
                if (id == 4'hD) begin
                    r = n + t;
                    if (r > 64'hFFFF_FFFF) e.err = 1'b1;
                end else if (id == 4'hE) begin
                    if (n < t) e.err = 1'b1;
                    r = n - t;
                end else begin
                    r = n * t;
                    if ((r >> 32) != 0) e.err = 1'b1;
                end
                if (!e.err) begin
                    e.pop = 1'b1;
                    e.wr  = 1'b1;
                    e.val = r[31:0];
                end
            end
        end
        return e;
    endfunction

    // Press a key (held 3 cycles when it is not a divide) and check the response
    task automatic do_op(input logic [3:0] id, input logic a, input string name, output exp_t e);
        int busy_cycles;
        logic stray;
        e = model(id, a, i_top, i_next, int'(i_count), m_err);
        i_key = {1'b1, id};
        i_alt = a;
        cycle();
        stray = 1'b0;
        if (e.div) begin
            n_checks++;
            if (o_busy !== 1'b1 || o_stack_push || o_stack_pop || o_stack_write)
                $display("FAIL %s start: busy=%b strobes=%b%b%b, required busy=1 strobes=000",
                         name, o_busy, o_stack_push, o_stack_pop, o_stack_write);
            else n_pass++;
            busy_cycles = 0;
            while (o_busy === 1'b1 && busy_cycles < 100) begin
                busy_cycles++;
                if (o_stack_push || o_stack_pop || o_stack_write) stray = 1'b1;
                // Keys pressed while busy must vanish
                if (busy_cycles == 5) i_key = 5'b0;
                if (busy_cycles == 6) begin i_key = 5'b11100; i_alt = 1'b0; end
                if (busy_cycles == 8) i_key = 5'b0;
                if (busy_cycles == 12) i_key = 5'b10000;
                if (busy_cycles == 14) i_key = 5'b0;
                cycle();
            end
            n_checks++;
            if (busy_cycles !== WIDTH + 1)
                $display("FAIL %s busy_len: got %0d cycles, required %0d", name, busy_cycles,
                         WIDTH + 1);
            else n_pass++;
            n_checks++;
            if (stray !== 1'b0)
                $display("FAIL %s busy_strobes: got strobe during busy, required none", name);
            else n_pass++;
            n_checks++;
            if (o_stack_pop !== 1'b1 || o_stack_write !== 1'b1 || o_stack_push !== 1'b0 ||
                o_stack_value !== e.val)
                $display("FAIL %s result: push/pop/wr=%b%b%b value=%0d, required 011 value=%0d",
                         name, o_stack_push, o_stack_pop, o_stack_write, o_stack_value, e.val);
            else n_pass++;
            cycle();
            n_checks++;
            if (o_stack_pop || o_stack_write || o_busy)
                $display("FAIL %s after_done: pop=%b wr=%b busy=%b, required all 0", name,
                         o_stack_pop, o_stack_write, o_busy);
            else n_pass++;
        end else begin
            n_checks++;
            if (o_stack_push !== e.push || o_stack_pop !== e.pop || o_stack_write !== e.wr ||
                o_busy !== 1'b0 || ((e.push || e.wr) && o_stack_value !== e.val))
                $display("FAIL %s cmd: push/pop/wr=%b%b%b busy=%b value=%0d, required %b%b%b busy=0 value=%0d",
                         name, o_stack_push, o_stack_pop, o_stack_write, o_busy, o_stack_value,
                         e.push, e.pop, e.wr, e.val);
            else n_pass++;
            for (int h = 0; h < 2; h++) begin
                cycle();
                if (o_stack_push || o_stack_pop || o_stack_write || o_busy) stray = 1'b1;
            end
            n_checks++;
            if (stray !== 1'b0)
                $display("FAIL %s hold: got repeat strobe while held, required none", name);
            else n_pass++;
        end
        n_checks++;
        if (o_error !== e.err)
            $display("FAIL %s error: got %b, required %b", name, o_error, e.err);
        else n_pass++;
        m_err = e.err;
        i_key = 5'b0;
        i_alt = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_key   = 5'b0;
        cycle();
        cycle();
        n_checks++;
        if (o_stack_push || o_stack_pop || o_stack_write || o_busy || o_error ||
            o_stack_value !== '0)
            $display("FAIL reset: push/pop/wr/busy/err=%b%b%b%b%b value=%0d, required all 0",
                     o_stack_push, o_stack_pop, o_stack_write, o_busy, o_error, o_stack_value);
        else n_pass++;
        i_reset = 1'b0;
        m_err = 1'b0;
        cycle();
    endtask

    task automatic test_digits();
        exp_t e;
        i_count = 6'd1;
        i_top   = 32'd0;
        do_op(4'h0, 1'b0, "digit1", e);
        i_top = e.val;
        do_op(4'h4, 1'b0, "digit2", e);
        i_top = e.val;
        do_op(4'h8, 1'b0, "digit3", e);
        n_checks++;
        if (o_stack_value !== 32'd0 || e.val !== 32'd123)
            $display("FAIL digit_chain: model value=%0d, required 123", e.val);
        else n_pass++;
        // Empty stack: push the digit itself
        i_count = 6'd0;
        i_top   = 32'd999;
        do_op(4'hA, 1'b0, "digit_empty", e);
        // Overflow of top*10+d
        i_count = 6'd1;
        i_top   = 32'd429496729;
        do_op(4'h6, 1'b0, "digit_ovf", e);
        do_op(4'hF, 1'b1, "digit_clear", e);
    endtask

    task automatic test_error_clear();
        exp_t e;
        i_top = 32'd7; i_next = 32'd5; i_count = 6'd2;
        do_op(4'hE, 1'b0, "sub_borrow", e);
        do_op(4'hD, 1'b0, "ignored_in_err", e);
        do_op(4'hF, 1'b1, "clear", e);
        i_top = 32'd7; i_next = 32'd9;
        do_op(4'hE, 1'b0, "sub_ok", e);
        i_count = 6'd1;
        do_op(4'hD, 1'b0, "underflow", e);
        do_op(4'hF, 1'b1, "clear2", e);
        i_top = 32'hFFFF_FFFF; i_next = 32'd1; i_count = 6'd2;
        do_op(4'hD, 1'b0, "add_carry", e);
        do_op(4'hF, 1'b1, "clear3", e);
    endtask

    task automatic test_divide();
        exp_t e;
        i_next = 32'd100; i_top = 32'd7; i_count = 6'd2;
        do_op(4'hD, 1'b1, "divide", e);
        do_op(4'hE, 1'b1, "modulo", e);
        i_top = 32'd0;
        do_op(4'hD, 1'b1, "div_zero", e);
        do_op(4'hF, 1'b1, "clear_dz", e);
    endtask

    task automatic test_multiply();
        exp_t e;
        i_next = 32'd65536; i_top = 32'd65536; i_count = 6'd2;
        do_op(4'hF, 1'b0, "mul_ovf", e);
        do_op(4'hF, 1'b1, "clear_mul", e);
        i_next = 32'd3; i_top = 32'd4;
        do_op(4'hF, 1'b0, "mul_ok", e);
    endtask

    task automatic test_enter();
        exp_t e;
        i_count = 6'd16;
        do_op(4'hC, 1'b0, "enter_full", e);
        do_op(4'hF, 1'b1, "clear_enter", e);
        i_count = 6'd3;
        i_top   = 32'd55;
        do_op(4'hC, 1'b0, "enter_ok", e);
        do_op(4'h7, 1'b0, "unused_7", e);
        do_op(4'hB, 1'b0, "unused_b", e);
    endtask

    task automatic test_reset_mid_divide();
        exp_t e;
        i_next = 32'd100; i_top = 32'd7; i_count = 6'd2;
        i_key = 5'b11101;
        i_alt = 1'b1;
        cycle();
        for (int c = 1; c < 10; c++) cycle();
        i_reset = 1'b1;
        i_key   = 5'b0;
        i_alt   = 1'b0;
        cycle();
        n_checks++;
        if (o_busy || o_stack_push || o_stack_pop || o_stack_write)
            $display("FAIL mid_reset: busy=%b strobes=%b%b%b, required all 0", o_busy,
                     o_stack_push, o_stack_pop, o_stack_write);
        else n_pass++;
        i_reset = 1'b0;
        m_err   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            n_checks++;
            if (o_busy || o_stack_push || o_stack_pop || o_stack_write) begin
                $display("FAIL mid_reset_idle: cycle %0d busy=%b strobes=%b%b%b, required all 0",
                         c, o_busy, o_stack_push, o_stack_pop, o_stack_write);
                break;
            end else n_pass++;
            if (c >= 1) break;
        end
        do_op(4'hD, 1'b1, "divide_after_reset", e);
    endtask

    task automatic test_random();
        exp_t e;
        logic [3:0] id;
        logic a;
        for (int it = 0; it < 60; it++) begin
            i_top   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 5000);
            i_next  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 100000);
            i_count = COUNT_W'($urandom_range(0, DEPTH));
            id      = 4'($urandom_range(0, 15));
            a       = 1'($urandom_range(0, 1));
            if (m_err && $urandom_range(0, 2) == 0) begin
                id = 4'hF;
                a  = 1'b1;
            end
            do_op(id, a, "random", e);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_key   = 5'b0;
        i_alt   = 1'b0;
        i_top   = '0;
        i_next  = '0;
        i_count = '0;
        cycle();
        test_reset();
        test_digits();
        test_error_clear();
        test_divide();
        test_multiply();
        test_enter();
        test_reset_mid_divide();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation ran past limit, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
- Parametrised keypad-to-stack controller for the RPN calculator. Sits between the numpad scanner and the operand stack.
- Converts numpad key codes into single-cycle push/pop/write commands, one command per key press.
- Adds an alternate mode (divide, modulo, clear), a multi-cycle restoring divider, and checking for overflow, underflow and divide-by-zero, with a sticky error flag.

Parameters:
WIDTH, 32, operand width in bits (stack entries, top/next, stack_value)
DEPTH, 16, stack capacity; a push is refused when count == DEPTH
COUNT_W, 6, width of count input; must satisfy 2^COUNT_W > DEPTH

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
key  input  5  numpad code; bit4 = key held, bits3:0 = key id (numpad encoding)
alt  input  1  mode switch, level; sampled on the press-event cycle only
top  input  WIDTH  stack top entry
next  input  WIDTH  stack entry below top
count  input  COUNT_W  number of valid stack entries
stack_push  output  1  pulse: push stack_value (count+1)
stack_pop  output  1  pulse: remove top entry
stack_write  output  1  pulse: write stack_value to top (with pop: the entry that becomes top)
stack_value  output  WIDTH  data for push/write
busy  output  1  divider running; key events ignored
error  output  1  sticky error flag

Behaviour:
- Reset: all outputs 0; FSM in IDLE; key history cleared. A reset mid-divide aborts the divide with no stack command issued.
- Press event: key[4]==1 while the registered key[4] from the previous cycle is 0.
  - Holding a key gives exactly one event.
  - Events while busy==1 are discarded. They are not queued.
- Command latency: outputs are registered and assert for exactly 1 cycle, on the cycle after the event. Otherwise all command strobes are 0.
- Digit keys (codes 10000=1, 10001=4, 10010=7, 10011=0, 10100=2, 10101=5, 10110=8, 11000=3, 11001=6, 11010=9):
  - Compute top*10+d in WIDTH+4 bits.
  - If count==0, use top=0 and issue push instead of write.
  - If the result exceeds 2^WIDTH-1: set error, no command.
- A (11100), enter: if count==DEPTH, set error. Otherwise push with stack_value=0.
- B/C/D with alt=0:
  - B: next+top; carry out sets error.
  - C: next-top; borrow (next<top) sets error.
  - D: next*top; a nonzero upper WIDTH bits of the 2*WIDTH product sets error.
  - On success: pop+write with the result.
- B/C with alt=1: divide and modulo, both requiring count>=2.
  - top==0 sets error.
  - Otherwise enter DIV: busy=1 on the cycle after the event.
  - Run a restoring divide on latched copies of next and top, one quotient bit per cycle, WIDTH cycles.
  - Then DONE: one cycle issuing pop+write with the quotient (B) or the remainder (C); busy drops in that same cycle.
  - Total: busy high WIDTH+1 cycles.
- D with alt=1, clear: clears error and issues no stack command. This is the only key accepted while error==1.
- Underflow: any binary op with count<2 sets error and issues no command.
- While error==1, all events other than alt+D are ignored.
- FSM: IDLE -> DIV (divide/modulo accepted) -> DONE (after WIDTH iterations) -> IDLE.
- Codes 10111 and 11011 are unused and ignored.
- Arithmetic is unsigned, and every result written fits WIDTH bits; no wrap-around is ever written.

Test Plan:
- Reset, then press 1, 2, 3 (each held 3 cycles) with count=1, top tracking the writes -> three single write pulses with values 1, 12, 123; no repeats while held.
- top=7, next=5, count=2, press C, alt=0 -> error=1, no strobes. Then press B -> still ignored. Then alt=1 + D -> error=0.
- WIDTH=32, next=100, top=7, count=2, alt=1, press B -> busy high 33 cycles, then pop+write with value 14. Repeat with C -> value 2. Keys pressed during busy produce nothing.
- next=65536, top=65536, press D alt=0 -> error. next=3, top=4 -> pop+write with value 12.
- count=DEPTH=16, press A -> error, no push. count=3, press A -> push with value 0.
- Assert reset on divide cycle 10 -> busy=0, no strobes, FSM idle next cycle; a subsequent divide completes normally.
